// File: rtl/sar_search_8_if.sv
// Probe/compare handshake bundle between the SAR search controller and its environment.
// The slave modport is the controller; master is whatever drives start/abort and models the comparator.
interface sar_search_8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             cmp_ge;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport master (
        output start, abort, cmp_ge,
        input  probe, busy, done, result, result_valid
    );

    modport slave (
        input  start, abort, cmp_ge,
        output probe, busy, done, result, result_valid
    );
endinterface

// File: rtl/sar_search_8.sv
// Successive-approximation search: drives the b side of an external a >= b comparator,
// resolving the target MSB first, one bit per trial of CMP_LAT+1 cycles.
module sar_search_8 #(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_search_8_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             result_valid_r, result_valid_s;
    logic [WIDTH-1:0] probe_r, probe_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    // Next-state, datapath and output decode; outputs are taken from the next state so they can be registered.
    always_comb begin
        state_s        = state_r;
        acc_s          = acc_r;
        idx_s          = idx_r;
        cnt_s          = cnt_r;
        result_s       = result_r;
        result_valid_s = result_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s        = ST_TRIAL;
                    acc_s          = '0;
                    idx_s          = IDX_TOP;
                    cnt_s          = '0;
                    result_valid_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRIAL: begin
                // abort outranks a same-edge decision, so a completing trial never reaches DONE
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r != CNT_LAST) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    acc_s[idx_r] = bus.cmp_ge;
                    cnt_s        = '0;
                    if (idx_r == '0) begin
                        state_s        = ST_DONE;
                        result_s       = acc_s;
                        result_valid_s = 1'b1;
                    end else begin
                        idx_s = idx_r - IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        probe_s = (state_s == ST_TRIAL) ? (acc_s | (ONE << idx_s)) : '0;
        busy_s  = (state_s == ST_TRIAL);
        done_s  = (state_s == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Search datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r          <= '0;
            idx_r          <= '0;
            cnt_r          <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            probe_r        <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            acc_r          <= acc_s;
            idx_r          <= idx_s;
            cnt_r          <= cnt_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
            probe_r        <= probe_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    assign bus.probe        = probe_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
endmodule

// File: tb/tb_sar_search_8.sv
// Self-checking bench for sar_search_8: table vectors, exhaustive and random targets,
// a latency-2 comparator with garbage outside its valid window, abort and reset corners.
module tb_sar_search_8;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sar_search_8_if #(.WIDTH(8)) if0 ();
    sar_search_8_if #(.WIDTH(8)) if2 ();

    sar_search_8 #(.WIDTH(8), .CMP_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sar_search_8 #(.WIDTH(8), .CMP_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [7:0] tgt0, tgt2;
    int n_chk = 0, n_fail = 0;
    int done_seen0 = 0, done_seen2 = 0, exp_done0 = 0, exp_done2 = 0;
    logic [7:0] last_p2 = 8'h00;
    int age2 = 0;

    typedef struct packed {
        logic [7:0]  target;
        logic [63:0] probes;
        logic [7:0]  result;
    } vec_t;
    vec_t tbl[6];

    // Combinational comparator for the default instance.
    assign if0.cmp_ge = (tgt0 >= if0.probe);

    // Two-cycle comparator: output is only meaningful once the probe has been stable for two edges.
    always @(negedge clk) begin
        if (if2.probe == last_p2) age2 = age2 + 1;
        else age2 = 0;
        last_p2 = if2.probe;
        if2.cmp_ge = (age2 >= 2) ? (tgt2 >= if2.probe) : 1'($urandom);
    end

    always @(negedge clk) begin
        if (if0.done === 1'b1) done_seen0 = done_seen0 + 1;
        if (if2.done === 1'b1) done_seen2 = done_seen2 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Trial k probes the known upper k bits of the target plus the next bit under test.
    function automatic logic [7:0] ref_probe(input logic [7:0] t, input int k);
        logic [7:0] keep;
        keep = 8'hFF;
        keep = keep << (8 - k);
        return (t & keep) | (8'h80 >> k);
    endfunction

    function automatic logic [63:0] ref_probes(input logic [7:0] t);
        logic [63:0] p;
        p = 64'h0;
        for (int k = 0; k < 8; k++) p[63-8*k -: 8] = ref_probe(t, k);
        return p;
    endfunction

    // Called at a negedge with dut0 idle; returns at the negedge after E9.
    task automatic run_search0(input logic [7:0] t, input logic [63:0] probes,
                               input logic [7:0] exp_res, input bit hold_start);
        tgt0 = t;
        if0.start = 1'b1;
        @(negedge clk);
        if (!hold_start) if0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("probe0", 32'(if0.probe), 32'(probes[63-8*k -: 8]));
            chk("busy0", 32'(if0.busy), 32'd1);
            chk("done0_early", 32'(if0.done), 32'd0);
        end
        @(negedge clk);
        chk("done0", 32'(if0.done), 32'd1);
        chk("busy0_done", 32'(if0.busy), 32'd0);
        chk("probe0_done", 32'(if0.probe), 32'd0);
        chk("result0", 32'(if0.result), 32'(exp_res));
        chk("rvalid0", 32'(if0.result_valid), 32'd1);
        exp_done0 = exp_done0 + 1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("done0_after", 32'(if0.done), 32'd0);
        chk("busy0_after", 32'(if0.busy), 32'd0);
        chk("result0_hold", 32'(if0.result), 32'(exp_res));
    endtask

    task automatic run_search2(input logic [7:0] t);
        tgt2 = t;
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (k > 0 || j > 0) @(negedge clk);
                chk("probe2", 32'(if2.probe), 32'(ref_probe(t, k)));
                chk("done2_early", 32'(if2.done), 32'd0);
            end
        end
        @(negedge clk);
        chk("done2", 32'(if2.done), 32'd1);
        chk("result2", 32'(if2.result), 32'(t));
        chk("rvalid2", 32'(if2.result_valid), 32'd1);
        exp_done2 = exp_done2 + 1;
        @(negedge clk);
        chk("done2_after", 32'(if2.done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{target: 8'hA5, probes: 64'h80C0A0B0A8A4A6A5, result: 8'hA5};
        tbl[1] = '{target: 8'h00, probes: 64'h8040201008040201, result: 8'h00};
        tbl[2] = '{target: 8'hFF, probes: 64'h80C0E0F0F8FCFEFF, result: 8'hFF};
        tbl[3] = '{target: 8'h01, probes: 64'h8040201008040201, result: 8'h01};
        tbl[4] = '{target: 8'h80, probes: 64'h80C0A09088848281, result: 8'h80};
        tbl[5] = '{target: 8'h7F, probes: 64'h804060707C7E7F00 >> 0, result: 8'h7F};
        tbl[5].probes = 64'h8040607078 << 24 | 64'h7C7E7F;

        rst_n = 1'b0;
        tgt0 = 8'h00; tgt2 = 8'h00;
        if0.start = 1'b0; if0.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_probe", 32'(if0.probe), 32'd0);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_done", 32'(if0.done), 32'd0);
        chk("rst_result", 32'(if0.result), 32'd0);
        chk("rst_rvalid", 32'(if0.result_valid), 32'd0);
        chk("rst_probe2", 32'(if2.probe), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors; one entry keeps start high through TRIAL and DONE.
        for (int i = 0; i < 6; i++)
            run_search0(tbl[i].target, tbl[i].probes, tbl[i].result, (i == 2));

        // Abort coinciding with the 4th decision edge.
        run_search0(8'hA5, ref_probes(8'hA5), 8'hA5, 1'b0);
        tgt0 = 8'hA5;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("ab_p0", 32'(if0.probe), 32'h80);
        @(negedge clk);
        chk("ab_p1", 32'(if0.probe), 32'hC0);
        @(negedge clk);
        chk("ab_p2", 32'(if0.probe), 32'hA0);
        @(negedge clk);
        chk("ab_p3", 32'(if0.probe), 32'hB0);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk("ab_busy", 32'(if0.busy), 32'd0);
        chk("ab_probe", 32'(if0.probe), 32'd0);
        chk("ab_done", 32'(if0.done), 32'd0);
        chk("ab_rvalid", 32'(if0.result_valid), 32'd0);
        chk("ab_result", 32'(if0.result), 32'hA5);
        repeat (8) @(negedge clk);
        chk("ab_idle", 32'(if0.busy), 32'd0);

        // start and abort together in IDLE: start wins, then the held abort cancels.
        if0.start = 1'b1;
        if0.abort = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("sa_busy", 32'(if0.busy), 32'd1);
        chk("sa_probe", 32'(if0.probe), 32'h80);
        @(negedge clk);
        if0.abort = 1'b0;
        chk("sa_busy2", 32'(if0.busy), 32'd0);
        chk("sa_result", 32'(if0.result), 32'hA5);
        chk("sa_rvalid", 32'(if0.result_valid), 32'd0);

        // Exhaustive sweep against the reference model.
        for (int t = 0; t < 256; t++)
            run_search0(8'(t), ref_probes(8'(t)), 8'(t), 1'b0);

        // Latency-2 comparator: fixed case then random targets.
        run_search2(8'h3C);
        for (int i = 0; i < 20; i++) run_search2(8'($urandom_range(0, 255)));

        // Asynchronous reset between edges in mid-search.
        tgt0 = 8'h5A;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_probe", 32'(if0.probe), 32'd0);
        chk("mr_busy", 32'(if0.busy), 32'd0);
        chk("mr_done", 32'(if0.done), 32'd0);
        chk("mr_result", 32'(if0.result), 32'd0);
        chk("mr_rvalid", 32'(if0.result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_search0(8'h5A, ref_probes(8'h5A), 8'h5A, 1'b0);

        repeat (2) @(negedge clk);
        chk("done_count0", 32'(done_seen0), 32'(exp_done0));
        chk("done_count2", 32'(done_seen2), 32'(exp_done2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
